nios2_oci_dct_trace_capture: RTL

- Parametrised capture block for the Nios II OCI direct-control-transfer (DCT) trace: records, buffers and streams DCT frames for the on-chip-instrumentation debug path.
- Generalises the fixed 30-bit/4-bit DCT test-bench interface to configurable buffer and count widths and a configurable FIFO depth.
- Adds a test-end protocol that emits an end marker, drains the FIFO, and reports done, overflow and drop status.
- Sits between the OCI trace logic and the debug/JTAG readout.

---
 rtl/nios2_oci_trace_pkg.sv | 33 +++
 rtl/nios2_oci_trace_fifo.sv | 53 +++++
 rtl/nios2_oci_dct_trace_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the Nios II OCI DCT trace capture path:
// frame tags, capture state encoding and the frame packing helper.
package nios2_oci_trace_pkg;

  localparam logic [1:0] TAG_DATA  = 2'b00;
  localparam logic [1:0] TAG_END   = 2'b01;
  localparam int         MAX_FRM_W = 128;

  typedef enum logic [2:0] {
    RUN,
    MARK,
    ENDED_WAIT,
    DRAIN,
    DONE
  } trace_state_e;

  // Widths are passed in so one helper serves every parameterisation;
  // callers zero-extend count/buffer and keep the low FRM_W bits.
  function automatic logic [MAX_FRM_W-1:0] pack_frame(
    input logic [1:0]           tag,
    input logic [MAX_FRM_W-1:0] count,
    input logic [MAX_FRM_W-1:0] buffer,
    input int                   cnt_w,
    input int                   dct_w
  );
    logic [MAX_FRM_W-1:0] frame;
    frame = ({{(MAX_FRM_W-2){1'b0}}, tag} << (cnt_w + dct_w))
          | (count << dct_w)
          | buffer;
    return frame;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is presented
// combinationally, occupancy is a registered 0..DEPTH level.
module nios2_oci_trace_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nios2_oci_dct_trace_capture.sv
// DCT trace capture: frames DCT records into a FIFO, inserts an END marker
// on test end, drains, and reports done/overflow/drop status.
module nios2_oci_dct_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter  int DCT_W  = 30,
  parameter  int CNT_W  = 4,
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 8,
  localparam int FRM_W  = 2 + CNT_W + DCT_W,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DCT_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_wr,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic [FRM_W-1:0]  frm_data,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              done
);

  trace_state_e         state;
  trace_state_e         state_next;
  logic                 te_q;
  logic                 wr_ok;
  logic                 data_req;
  logic                 end_req;
  logic                 drop;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [FRM_W-1:0]     head_data;
  logic [MAX_FRM_W-1:0] push_packed;
  logic                 unused_packed_hi;

  assign wr_ok     = dct_wr && (dct_count != '0);
  assign frm_valid = !empty;
  assign pop       = frm_valid && frm_ready;
  assign frm_data  = empty ? '0 : head_data;
  assign done      = (state == DONE);

  // Captured data always goes ahead of the END marker; the marker waits for space rather than dropping.
  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    end_req    = 1'b0;
    case (state)
      RUN: begin
        data_req = wr_ok;
        if ((test_ending && !te_q) || test_has_ended) state_next = MARK;
      end
      MARK: begin
        if (wr_ok) begin
          data_req = 1'b1;
        end else begin
          end_req = 1'b1;
          if (!full || pop) state_next = test_has_ended ? DRAIN : ENDED_WAIT;
        end
      end
      ENDED_WAIT: begin
        data_req = wr_ok;
        if (test_has_ended) state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_level == '0) state_next = DONE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = RUN;
    endcase
  end

  assign drop = data_req && full && !pop;

  always_comb begin
    push_packed = pack_frame(end_req ? TAG_END : TAG_DATA,
                             end_req ? '0 : MAX_FRM_W'(dct_count),
                             end_req ? '0 : MAX_FRM_W'(dct_buffer),
                             CNT_W, DCT_W);
  end

  assign unused_packed_hi = ^push_packed[MAX_FRM_W-1:FRM_W];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      te_q       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      te_q  <= test_ending;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  nios2_oci_trace_fifo #(
    .WIDTH (FRM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_req || end_req),
    .pop     (pop),
    .wr_data (push_packed[FRM_W-1:0]),
    .rd_data (head_data),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

endmodule
